// File: rtl/swc_sequencer.sv
// Host-side initiator for the Swc: expands one load/run request into the LD0/LD1/LD2[/CCU|CCD] stream.
// Optional WAIT watchdog is compiled in when SWC_SEQ_TIMEOUT_EN is defined.

`ifndef Swc_NOP
`define Swc_NOP 4'h0
`endif
`ifndef Swc_LD0
`define Swc_LD0 4'h1
`endif
`ifndef Swc_LD1
`define Swc_LD1 4'h2
`endif
`ifndef Swc_LD2
`define Swc_LD2 4'h3
`endif
`ifndef Swc_CCU
`define Swc_CCU 4'h4
`endif
`ifndef Swc_CCD
`define Swc_CCD 4'h5
`endif

module swc_sequencer #(
    parameter logic [15:0] TimeoutCycles = 16'd1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  cmd,
    input  logic [23:0] value,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        abort,
    input  logic        swc_ready,
    output logic [11:0] inst,
    output logic        inst_en,
    output logic        done,
    output logic        aborted,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD0,
        S_LD1,
        S_LD2,
        S_GO,
        S_WAIT,
        S_STOP
    } state_t;

    localparam logic [1:0] CMD_SET  = 2'b00;
    localparam logic [1:0] CMD_RUND = 2'b10;
    localparam logic [1:0] CMD_RSVD = 2'b11;

    state_t      state_reg, state_next;
    logic [1:0]  cmd_reg, cmd_next;
    logic [23:0] value_reg, value_next;
    logic        grace_reg, grace_next;
    logic [11:0] inst_next;
    logic        inst_en_next;
    logic        done_next;
    logic        aborted_next;
    logic        timeout_hit;

`ifdef SWC_SEQ_TIMEOUT_EN
    logic [15:0] wd_reg, wd_next;

    always_comb begin
        wd_next = wd_reg;
        if (state_reg == S_GO) begin
            wd_next = '0;
        end else if (state_reg == S_WAIT) begin
            wd_next = wd_reg + 16'd1;
        end
    end

    // Fires on the edge that completes the TimeoutCycles-th WAIT cycle.
    assign timeout_hit = (state_reg == S_WAIT) && (wd_reg == TimeoutCycles - 16'd1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_reg <= '0;
        end else begin
            wd_reg <= wd_next;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TimeoutCycles;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        cmd_next     = cmd_reg;
        value_next   = value_reg;
        grace_next   = 1'b0;
        inst_next    = {`Swc_NOP, 8'h00};
        inst_en_next = 1'b0;
        done_next    = 1'b0;
        aborted_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd == CMD_RSVD) begin
                        done_next    = 1'b1;
                        aborted_next = 1'b1;
                    end else begin
                        cmd_next     = cmd;
                        value_next   = value;
                        state_next   = S_LD0;
                        inst_next    = {`Swc_LD0, value[7:0]};
                        inst_en_next = 1'b1;
                    end
                end
            end
            S_LD0: begin
                state_next   = S_LD1;
                inst_next    = {`Swc_LD1, value_reg[15:8]};
                inst_en_next = 1'b1;
            end
            S_LD1: begin
                state_next   = S_LD2;
                inst_next    = {`Swc_LD2, value_reg[23:16]};
                inst_en_next = 1'b1;
            end
            S_LD2: begin
                if (cmd_reg == CMD_SET) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end else begin
                    state_next   = S_GO;
                    inst_next    = {(cmd_reg == CMD_RUND) ? `Swc_CCD : `Swc_CCU, 8'h00};
                    inst_en_next = 1'b1;
                end
            end
            S_GO: begin
                // First WAIT cycle ignores swc_ready while the Swc drops it.
                state_next = S_WAIT;
                grace_next = 1'b1;
            end
            S_WAIT: begin
                if (abort) begin
                    state_next   = S_STOP;
                    inst_en_next = 1'b1;
                end else if (!grace_reg && swc_ready) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end else if (timeout_hit) begin
                    state_next   = S_STOP;
                    inst_en_next = 1'b1;
                end
            end
            S_STOP: begin
                state_next   = S_IDLE;
                done_next    = 1'b1;
                aborted_next = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cmd_reg   <= CMD_SET;
            value_reg <= '0;
            grace_reg <= 1'b0;
            inst      <= {`Swc_NOP, 8'h00};
            inst_en   <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            state_reg <= state_next;
            cmd_reg   <= cmd_next;
            value_reg <= value_next;
            grace_reg <= grace_next;
            inst      <= inst_next;
            inst_en   <= inst_en_next;
            done      <= done_next;
            aborted   <= aborted_next;
            busy      <= (state_next != S_IDLE);
            // Held low during the done cycle so the next accept lands one cycle later.
            cmd_ready <= (state_next == S_IDLE) && !done_next;
        end
    end

endmodule

// File: tb/tb_swc_sequencer.sv
// Directed bench for swc_sequencer with a small behavioural Swc counter on its instruction port.
// The timeout scenario runs only when SWC_SEQ_TIMEOUT_EN is defined.

module tb_swc_sequencer;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LD0 = 4'h1;
    localparam logic [3:0] OP_LD1 = 4'h2;
    localparam logic [3:0] OP_LD2 = 4'h3;
    localparam logic [3:0] OP_CCU = 4'h4;
    localparam logic [3:0] OP_CCD = 4'h5;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  cmd;
    logic [23:0] value;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        abort;
    logic        swc_ready;
    logic [11:0] inst;
    logic        inst_en;
    logic        done;
    logic        aborted;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    swc_sequencer #(.TimeoutCycles(16'd8)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd       (cmd),
        .value     (value),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .abort     (abort),
        .swc_ready (swc_ready),
        .inst      (inst),
        .inst_en   (inst_en),
        .done      (done),
        .aborted   (aborted),
        .busy      (busy)
    );

    // Swc model: ready is a registered copy of !counting, so it drops one cycle after CCU/CCD.
    logic [23:0] swc_cnt;
    logic        swc_counting;
    logic        swc_up;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            swc_cnt      <= '0;
            swc_counting <= 1'b0;
            swc_up       <= 1'b0;
            swc_ready    <= 1'b1;
        end else begin
            swc_ready <= !swc_counting;
            if (inst_en) begin
                case (inst[11:8])
                    OP_LD0:  swc_cnt[7:0]   <= inst[7:0];
                    OP_LD1:  swc_cnt[15:8]  <= inst[7:0];
                    OP_LD2:  swc_cnt[23:16] <= inst[7:0];
                    OP_CCU:  begin swc_counting <= 1'b1; swc_up <= 1'b1; end
                    OP_CCD:  begin swc_counting <= 1'b1; swc_up <= 1'b0; end
                    default: swc_counting <= 1'b0;
                endcase
            end else if (swc_counting) begin
                swc_cnt <= swc_up ? swc_cnt + 24'd1 : swc_cnt - 24'd1;
                if ((swc_up && swc_cnt == 24'hFFFFFF) || (!swc_up && swc_cnt == 24'h000001))
                    swc_counting <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic start_cmd(input logic [1:0] c, input logic [23:0] v);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'h1);
        cmd       = c;
        value     = v;
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic check_loads(input string tag, input logic [23:0] v);
        check({tag, "_ld0"}, 32'({inst_en, inst}), 32'({1'b1, OP_LD0, v[7:0]}));
        @(negedge clock);
        check({tag, "_ld1"}, 32'({inst_en, inst}), 32'({1'b1, OP_LD1, v[15:8]}));
        @(negedge clock);
        check({tag, "_ld2"}, 32'({inst_en, inst}), 32'({1'b1, OP_LD2, v[23:16]}));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        logic [11:0] seen[$];
        logic [11:0] exp_seq[7];
        int lat;
        int en_cnt;
        int n_done;
        int early;
        int acc_cyc;

        cmd       = 2'b00;
        value     = '0;
        cmd_valid = 1'b0;
        abort     = 1'b0;

        // Reset values
        repeat (2) @(negedge clock);
        check("rst_inst", 32'(inst), 32'h000);
        check("rst_inst_en", 32'(inst_en), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_aborted", 32'(aborted), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        reset = 1'b0;
        @(negedge clock);

        // SET, with abort held during the loads (must be ignored)
        start_cmd(2'b00, 24'hF2F1F0);
        check("set_busy", 32'(busy), 32'h1);
        check("set_cmd_ready", 32'(cmd_ready), 32'h0);
        abort = 1'b1;
        check_loads("set", 24'hF2F1F0);
        abort = 1'b0;
        @(negedge clock);
        check("set_en_off", 32'(inst_en), 32'h0);
        check("set_done", 32'(done), 32'h1);
        check("set_aborted", 32'(aborted), 32'h0);
        check("set_busy_fall", 32'(busy), 32'h0);
        check("set_ready_in_done", 32'(cmd_ready), 32'h0);
        @(negedge clock);
        check("set_done_pulse", 32'(done), 32'h0);
        check("set_ready_after", 32'(cmd_ready), 32'h1);

        // RUNU: counts FFFFFA up to zero; done 9 cycles after CCU
        start_cmd(2'b01, 24'hFFFFFA);
        check_loads("runu", 24'hFFFFFA);
        @(negedge clock);
        check("runu_ccu", 32'({inst_en, inst}), 32'({1'b1, OP_CCU, 8'h00}));
        lat = 0;
        en_cnt = 0;
        while (!done && lat < 40) begin
            @(negedge clock);
            lat++;
            if (inst_en) en_cnt++;
        end
        check("runu_latency", 32'(lat), 32'd9);
        check("runu_no_extra_inst", 32'(en_cnt), 32'd0);
        check("runu_aborted", 32'(aborted), 32'h0);
        check("runu_busy", 32'(busy), 32'h0);
        @(negedge clock);

        // RUND with abort in the third WAIT cycle
        start_cmd(2'b10, 24'h000006);
        check_loads("rund", 24'h000006);
        @(negedge clock);
        check("rund_ccd", 32'({inst_en, inst}), 32'({1'b1, OP_CCD, 8'h00}));
        repeat (3) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_nop", 32'({inst_en, inst}), 32'({1'b1, OP_NOP, 8'h00}));
        check("abort_no_done_yet", 32'(done), 32'h0);
        @(negedge clock);
        check("abort_en_off", 32'(inst_en), 32'h0);
        check("abort_done", 32'(done), 32'h1);
        check("abort_aborted", 32'(aborted), 32'h1);
        @(negedge clock);
        check("abort_done_pulse", 32'(done), 32'h0);
        repeat (3) @(negedge clock);
        check("abort_cnt_frozen", 32'(swc_cnt), 32'h000003);

        // RUND with a second SET held pending behind it
        cmd       = 2'b10;
        value     = 24'h000002;
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd   = 2'b00;
        value = 24'h0A0B0C;
        n_done = 0;
        early = 0;
        acc_cyc = -1;
        for (int c = 0; c < 20; c++) begin
            if (inst_en) seen.push_back(inst);
            if (done) n_done++;
            else if (cmd_ready && n_done == 0) early++;
            if (inst_en && inst == {OP_LD0, 8'h0C}) begin
                acc_cyc = c;
                cmd_valid = 1'b0;
            end
            @(negedge clock);
        end
        cmd_valid = 1'b0;
        exp_seq = '{{OP_LD0, 8'h02}, {OP_LD1, 8'h00}, {OP_LD2, 8'h00}, {OP_CCD, 8'h00},
                    {OP_LD0, 8'h0C}, {OP_LD1, 8'h0B}, {OP_LD2, 8'h0A}};
        check("held_no_early_ready", 32'(early), 32'd0);
        check("held_accept_cycle", 32'(acc_cyc), 32'd10);
        check("held_done_count", 32'(n_done), 32'd2);
        check("held_inst_count", 32'(seen.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < seen.size())
                check($sformatf("held_inst_%0d", i), 32'(seen[i]), 32'(exp_seq[i]));
        end

        // Reset in the middle of a RUNU
        start_cmd(2'b01, 24'h00FF00);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("arst_inst_en", 32'(inst_en), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_inst", 32'(inst), 32'h000);
        @(negedge clock);
        reset = 1'b0;
        en_cnt = 0;
        repeat (6) begin
            @(negedge clock);
            if (inst_en) en_cnt++;
        end
        check("arst_no_inst", 32'(en_cnt), 32'd0);
        start_cmd(2'b00, 24'h123456);
        check_loads("post_rst", 24'h123456);
        @(negedge clock);
        check("post_rst_done", 32'(done), 32'h1);
        check("post_rst_aborted", 32'(aborted), 32'h0);
        @(negedge clock);

        // Reserved command
        start_cmd(2'b11, 24'hABCDEF);
        check("rsvd_en", 32'(inst_en), 32'h0);
        check("rsvd_done", 32'(done), 32'h1);
        check("rsvd_aborted", 32'(aborted), 32'h1);
        check("rsvd_busy", 32'(busy), 32'h0);
        check("rsvd_ready_in_done", 32'(cmd_ready), 32'h0);
        @(negedge clock);
        check("rsvd_done_pulse", 32'(done), 32'h0);
        check("rsvd_ready_after", 32'(cmd_ready), 32'h1);

`ifdef SWC_SEQ_TIMEOUT_EN
        // Watchdog: counting up from zero never finishes, so NOP after 8 WAIT cycles
        start_cmd(2'b01, 24'h000000);
        check_loads("tmo", 24'h000000);
        @(negedge clock);
        check("tmo_ccu", 32'({inst_en, inst}), 32'({1'b1, OP_CCU, 8'h00}));
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!inst_en && lat < 40);
        check("tmo_latency", 32'(lat), 32'd9);
        check("tmo_nop", 32'({inst_en, inst}), 32'({1'b1, OP_NOP, 8'h00}));
        @(negedge clock);
        check("tmo_done", 32'(done), 32'h1);
        check("tmo_aborted", 32'(aborted), 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
